// File: rtl/synch_fifo_ext.sv
// Single-clock FIFO with almost-full/empty thresholds, occupancy count, read-valid strobe and error pulses.
// Optional first-word-fall-through read path enabled by defining SYNCH_FIFO_FWFT_EN.
module synch_fifo_ext #(
    parameter int unsigned  FIFO_WIDTH = 16,
    parameter int unsigned  FIFO_DEPTH = 16,
    parameter int unsigned  AFULL_TH   = 12,
    parameter int unsigned  AEMPTY_TH  = 4,
    localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] write_data,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] read_data,
    output logic                  rd_valid,
    output logic                  fifo_empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   data_count
);

    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic                  overflow_q, underflow_q;
    logic                  valid_wr, valid_rd;

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // Status derived from the registered pointers; the wrap bit separates full from empty.
    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign data_count   = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (data_count >= PTR_WIDTH'(AFULL_TH));
    assign almost_empty = (data_count <= PTR_WIDTH'(AEMPTY_TH));

    assign valid_wr = wr_en && !fifo_full;
    assign valid_rd = rd_en && !fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_WIDTH'(valid_wr);
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(valid_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= wr_en && fifo_full;
            underflow_q <= rd_en && fifo_empty;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (valid_wr) begin
            mem_q[wr_addr] <= write_data;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

`ifdef SYNCH_FIFO_FWFT_EN
    assign read_data = mem_q[rd_addr];
    assign rd_valid  = !fifo_empty;
`else
    logic [FIFO_WIDTH-1:0] read_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= valid_rd;
            if (valid_rd) begin
                read_data_q <= mem_q[rd_addr];
            end
        end
    end

    assign read_data = read_data_q;
    assign rd_valid  = rd_valid_q;
`endif

endmodule
